// File: rtl/decode_pkg.sv
// Shared types and instruction field positions for the WISC decode stage.
package decode_pkg;

   typedef enum logic [1:0] {
      IMM4 = 2'b00,
      IMM9 = 2'b01,
      LLB  = 2'b10,
      LHB  = 2'b11
   } imm_size_t;

   localparam int INSTR_W    = 16;
   localparam int FIELD_W    = 4;
   localparam int OPCODE_LSB = 12;
   localparam int DST_LSB    = 8;
   localparam int SRC1_LSB   = 4;
   localparam int SRC2_LSB   = 0;
   localparam int REG0       = 0;

endpackage

// File: rtl/decode_regfile.sv
// NREG x DATA_W register file, two async reads and one sync write; register 0 reads as zero.
// DECODE_WB_BYPASS_EN forwards same-cycle write data to matching reads.
module decode_regfile
   import decode_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREG   = 16,
   parameter int REG_AW = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] raddr1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] regs [NREG];
   logic              wr_live;

   assign wr_live = we && (waddr != REG_AW'(REG0));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_live) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = regs[raddr1];
      rdata2 = regs[raddr2];
`ifdef DECODE_WB_BYPASS_EN
      if (wr_live && (waddr == raddr1)) rdata1 = wdata;
      if (wr_live && (waddr == raddr2)) rdata2 = wdata;
`endif
      if (raddr1 == REG_AW'(REG0)) rdata1 = '0;
      if (raddr2 == REG_AW'(REG0)) rdata2 = '0;
   end

endmodule

// File: rtl/decode_stage_pipe.sv
// WISC decode stage: IF/ID register, regfile read, immediate/branch build, hazard stall, ID/EX register.
// DECODE_WB_BYPASS_EN selects write-forwarding instead of a writeback-collision stall.
module decode_stage_pipe
   import decode_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREG   = 16,
   parameter int REG_AW = $clog2(NREG)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_valid,
   input  logic [INSTR_W-1:0] if_instr,
   input  logic [DATA_W-1:0]  if_pc,
   output logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   input  logic [1:0]         ctl_imm_size,
   input  logic               ctl_reg_src,
   input  logic               ctl_branch_src,
   input  logic               ctl_use1,
   input  logic               ctl_use2,
   input  logic               ex_ready,
   input  logic               ex_load,
   input  logic [REG_AW-1:0]  ex_dst,
   input  logic               flush,
   input  logic               wb_we,
   input  logic [REG_AW-1:0]  wb_dst,
   input  logic [DATA_W-1:0]  wb_data,
   output logic               ex_valid,
   output logic [DATA_W-1:0]  ex_imm,
   output logic [DATA_W-1:0]  ex_rdata1,
   output logic [DATA_W-1:0]  ex_rdata2,
   output logic [DATA_W-1:0]  ex_pc_branch,
   output logic [REG_AW-1:0]  ex_dst_out,
   output logic               stall
);

   logic               ifid_valid;
   logic [INSTR_W-1:0] ifid_instr;
   logic [DATA_W-1:0]  ifid_pc;
   logic [REG_AW-1:0]  src1, src2, dst;
   logic [DATA_W-1:0]  rdata1, rdata2, imm, pc_branch;
   logic               load_hazard, wb_hazard, advance;

   assign src1 = REG_AW'(ifid_instr[SRC1_LSB +: FIELD_W]);
   assign src2 = ctl_reg_src ? REG_AW'(ifid_instr[DST_LSB +: FIELD_W])
                             : REG_AW'(ifid_instr[SRC2_LSB +: FIELD_W]);
   assign dst  = REG_AW'(ifid_instr[DST_LSB +: FIELD_W]);

   decode_regfile #(.DATA_W(DATA_W), .NREG(NREG), .REG_AW(REG_AW)) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (src1),
      .raddr2 (src2),
      .rdata1 (rdata1),
      .rdata2 (rdata2),
      .we     (wb_we),
      .waddr  (wb_dst),
      .wdata  (wb_data)
   );

   assign load_hazard = ifid_valid && ex_valid && ex_load && (ex_dst != REG_AW'(REG0)) &&
                        ((ctl_use1 && (src1 == ex_dst)) || (ctl_use2 && (src2 == ex_dst)));

   // Without forwarding, a read racing a write to the same register waits for the write to land.
`ifdef DECODE_WB_BYPASS_EN
   assign wb_hazard = 1'b0;
`else
   assign wb_hazard = ifid_valid && wb_we && (wb_dst != REG_AW'(REG0)) &&
                      ((ctl_use1 && (src1 == wb_dst)) || (ctl_use2 && (src2 == wb_dst)));
`endif

   assign stall    = load_hazard || wb_hazard;
   assign advance  = ifid_valid && !stall && (ex_ready || !ex_valid);
   assign id_ready = !ifid_valid || advance;
   assign id_instr = ifid_instr;

   always_comb begin
      imm = rdata2;
      unique case (imm_size_t'(ctl_imm_size))
         IMM4: imm = {{(DATA_W-4){ifid_instr[3]}}, ifid_instr[3:0]};
         IMM9: imm = {{(DATA_W-9){ifid_instr[8]}}, ifid_instr[8:0]};
         LLB:  imm[7:0]  = ifid_instr[7:0];
         LHB:  imm[15:8] = ifid_instr[7:0];
      endcase
   end

   assign pc_branch = ctl_branch_src ? rdata1 : (ifid_pc + (imm << 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc    <= '0;
      end else if (flush) begin
         ifid_valid <= 1'b0;
      end else if (id_ready) begin
         ifid_valid <= if_valid;
         if (if_valid) begin
            ifid_instr <= if_instr;
            ifid_pc    <= if_pc;
         end
      end
   end

   // A consumed or stalled slot drains to a bubble; with ex_ready low everything holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_imm       <= '0;
         ex_rdata1    <= '0;
         ex_rdata2    <= '0;
         ex_pc_branch <= '0;
         ex_dst_out   <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (advance) begin
         ex_valid     <= 1'b1;
         ex_imm       <= imm;
         ex_rdata1    <= rdata1;
         ex_rdata2    <= rdata2;
         ex_pc_branch <= pc_branch;
         ex_dst_out   <= dst;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Testbench for decode_stage_pipe: directed scenarios plus a randomized run checked by a scoreboard.
// Honors DECODE_WB_BYPASS_EN for the writeback-collision expectations.
module tb_decode_stage_pipe;

   localparam int DATA_W = 16;
   localparam int NREG   = 16;
   localparam int REG_AW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_valid;
   logic [15:0]       if_instr;
   logic [DATA_W-1:0] if_pc;
   logic              id_ready;
   logic [15:0]       id_instr;
   logic [1:0]        ctl_imm_size;
   logic              ctl_reg_src, ctl_branch_src, ctl_use1, ctl_use2;
   logic              ex_ready, ex_load;
   logic [REG_AW-1:0] ex_dst;
   logic              flush, wb_we;
   logic [REG_AW-1:0] wb_dst;
   logic [DATA_W-1:0] wb_data;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_imm, ex_rdata1, ex_rdata2, ex_pc_branch;
   logic [REG_AW-1:0] ex_dst_out;
   logic              stall;

   int checks   = 0;
   int failures = 0;
   int issued   = 0;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
   } txn_t;

   txn_t        pending[$];
   logic [15:0] ref_regs [NREG];
   logic        mon_en = 1'b0;
   logic        man_en = 1'b1;
   logic [1:0]  m_size;
   logic        m_rsrc, m_bsrc, m_u1, m_u2;
   logic [15:0] cur_imm, cur_r1, cur_r2, cur_pb;
   logic [3:0]  cur_dst;
   logic        cur_u1, cur_u2;

   always #5 clk = ~clk;

   decode_stage_pipe #(.DATA_W(DATA_W), .NREG(NREG)) dut (
      .clk            (clk),
      .rst            (rst),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .ctl_imm_size   (ctl_imm_size),
      .ctl_reg_src    (ctl_reg_src),
      .ctl_branch_src (ctl_branch_src),
      .ctl_use1       (ctl_use1),
      .ctl_use2       (ctl_use2),
      .ex_ready       (ex_ready),
      .ex_load        (ex_load),
      .ex_dst         (ex_dst),
      .flush          (flush),
      .wb_we          (wb_we),
      .wb_dst         (wb_dst),
      .wb_data        (wb_data),
      .ex_valid       (ex_valid),
      .ex_imm         (ex_imm),
      .ex_rdata1      (ex_rdata1),
      .ex_rdata2      (ex_rdata2),
      .ex_pc_branch   (ex_pc_branch),
      .ex_dst_out     (ex_dst_out),
      .stall          (stall)
   );

   // Stand-in control unit: directed tests set fields by hand, random traffic decodes opcode bits.
   always_comb begin
      if (man_en) begin
         ctl_imm_size   = m_size;
         ctl_reg_src    = m_rsrc;
         ctl_branch_src = m_bsrc;
         ctl_use1       = m_u1;
         ctl_use2       = m_u2;
      end else begin
         ctl_imm_size   = id_instr[13:12];
         ctl_reg_src    = id_instr[14];
         ctl_branch_src = id_instr[15];
         ctl_use1       = id_instr[15] | id_instr[0];
         ctl_use2       = id_instr[13] | id_instr[1];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic set_ctl(input logic [1:0] size, input logic rsrc, input logic bsrc,
                          input logic u1, input logic u2);
      m_size = size; m_rsrc = rsrc; m_bsrc = bsrc; m_u1 = u1; m_u2 = u2;
   endtask

   task automatic idle();
      if_valid = 1'b0; if_instr = '0; if_pc = '0;
      ex_ready = 1'b1; ex_load = 1'b0; ex_dst = '0;
      flush = 1'b0; wb_we = 1'b0; wb_dst = '0; wb_data = '0;
   endtask

   task automatic applyStimulus();
      if_valid = ($urandom_range(0, 3) != 0);
      if_instr = 16'($urandom);
      if_pc    = 16'($urandom);
      ex_ready = ($urandom_range(0, 3) != 0);
      ex_load  = 1'($urandom);
      ex_dst   = 4'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 19) == 0);
      wb_we    = 1'($urandom);
      wb_dst   = 4'($urandom_range(0, 15));
      wb_data  = 16'($urandom);
   endtask

   // Reference decode of one instruction from the architectural register contents.
   task automatic compute_exp(input txn_t t);
      logic [3:0]  s1, s2;
      int          v;
      int unsigned sum;
      s1 = t.instr[7:4];
      s2 = t.instr[14] ? t.instr[11:8] : t.instr[3:0];
      cur_r1 = ref_regs[s1];
      cur_r2 = ref_regs[s2];
      case (t.instr[13:12])
         2'd0: begin v = int'(t.instr[3:0]); if (v >= 8) v -= 16; cur_imm = 16'(v); end
         2'd1: begin v = int'(t.instr[8:0]); if (v >= 256) v -= 512; cur_imm = 16'(v); end
         2'd2: cur_imm = (cur_r2 & 16'hFF00) | {8'h00, t.instr[7:0]};
         default: cur_imm = (cur_r2 & 16'h00FF) | ({8'h00, t.instr[7:0]} * 16'd256);
      endcase
      sum    = 32'(t.pc) + 32'd2 * 32'(cur_imm);
      cur_pb = t.instr[15] ? cur_r1 : 16'(sum % 32'd65536);
      cur_dst = t.instr[11:8];
      cur_u1  = t.instr[15] | t.instr[0];
      cur_u2  = t.instr[13] | t.instr[1];
   endtask

   task automatic compare_ex();
      checkOutput("sb_ex_imm", 32'(ex_imm), 32'(cur_imm));
      checkOutput("sb_ex_pc_branch", 32'(ex_pc_branch), 32'(cur_pb));
      checkOutput("sb_ex_dst_out", 32'(ex_dst_out), 32'(cur_dst));
      if (cur_u1) checkOutput("sb_ex_rdata1", 32'(ex_rdata1), 32'(cur_r1));
      if (cur_u2) checkOutput("sb_ex_rdata2", 32'(ex_rdata2), 32'(cur_r2));
   endtask

   // Monitor: snapshots the handshakes before each edge, then pops and checks what entered ID/EX.
   initial begin : monitor
      logic        c_acc, c_flush, c_exv, c_exr, c_wbwe;
      logic [3:0]  c_wbd;
      logic [15:0] c_wbdata, c_instr, c_pc;
      txn_t        t;
      forever begin
         @(negedge clk);
         #1;
         c_acc    = if_valid && id_ready && !flush;
         c_flush  = flush;
         c_exv    = ex_valid;
         c_exr    = ex_ready;
         c_wbwe   = wb_we;
         c_wbd    = wb_dst;
         c_wbdata = wb_data;
         c_instr  = if_instr;
         c_pc     = if_pc;
         @(posedge clk);
         if (mon_en) begin
            if (c_wbwe && (c_wbd != 4'd0)) ref_regs[c_wbd] = c_wbdata;
            #1;
            if (c_flush) begin
               pending.delete();
               checkOutput("sb_flush_ex_valid", 32'(ex_valid), 32'd0);
            end else begin
               if (c_exv && !c_exr) begin
                  checkOutput("sb_hold_ex_valid", 32'(ex_valid), 32'd1);
                  compare_ex();
               end else if (ex_valid) begin
                  if (pending.size() == 0) begin
                     checkOutput("sb_issue_without_accept", 32'(pending.size()), 32'd1);
                  end else begin
                     t = pending.pop_front();
                     compute_exp(t);
                     issued++;
                     compare_ex();
                  end
               end
               if (c_acc) pending.push_back('{instr: c_instr, pc: c_pc});
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
      set_ctl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      checkOutput("reset_ex_valid", 32'(ex_valid), 32'd0);
      checkOutput("reset_id_ready", 32'(id_ready), 32'd1);
      checkOutput("reset_stall", 32'(stall), 32'd0);
      checkOutput("reset_ex_imm", 32'(ex_imm), 32'd0);
      checkOutput("reset_ex_rdata1", 32'(ex_rdata1), 32'd0);
      checkOutput("reset_ex_pc_branch", 32'(ex_pc_branch), 32'd0);
      checkOutput("reset_ex_dst_out", 32'(ex_dst_out), 32'd0);
      checkOutput("reset_id_instr", 32'(id_instr), 32'd0);

      // ADD r3,r1,r2 with r1=5, r2=7
      wb_we = 1'b1; wb_dst = 4'd1; wb_data = 16'd5; cyc();
      wb_dst = 4'd2; wb_data = 16'd7; cyc();
      wb_we = 1'b0; if_valid = 1'b1; if_instr = 16'h0312; if_pc = 16'h0100;
      set_ctl(2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc();
      if_valid = 1'b0;
      checkOutput("t1_latency_ex_valid", 32'(ex_valid), 32'd0);
      cyc();
      checkOutput("t1_ex_valid", 32'(ex_valid), 32'd1);
      checkOutput("t1_rdata1", 32'(ex_rdata1), 32'd5);
      checkOutput("t1_rdata2", 32'(ex_rdata2), 32'd7);
      checkOutput("t1_dst", 32'(ex_dst_out), 32'd3);
      checkOutput("t1_imm", 32'(ex_imm), 32'd2);
      checkOutput("t1_pc_branch", 32'(ex_pc_branch), 32'h0104);

      // imm9 = -1, branch target = pc - 2
      if_valid = 1'b1; if_instr = 16'h01FF; if_pc = 16'h0010;
      set_ctl(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      if_valid = 1'b0;
      cyc();
      checkOutput("t2_ex_valid", 32'(ex_valid), 32'd1);
      checkOutput("t2_imm", 32'(ex_imm), 32'hFFFF);
      checkOutput("t2_pc_branch", 32'(ex_pc_branch), 32'h000E);

      // Load-use: LW r4 then a reader of r4
      if_valid = 1'b1; if_instr = 16'h0400; set_ctl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      if_instr = 16'h0540;
      cyc();
      if_valid = 1'b0; set_ctl(2'd0, 1'b0, 1'b0, 1'b1, 1'b0); ex_load = 1'b1; ex_dst = 4'd4;
      #1;
      checkOutput("t3_stall", 32'(stall), 32'd1);
      checkOutput("t3_id_ready", 32'(id_ready), 32'd0);
      cyc();
      checkOutput("t3_bubble_ex_valid", 32'(ex_valid), 32'd0);
      checkOutput("t3_stall_released", 32'(stall), 32'd0);
      ex_load = 1'b0;
      cyc();
      checkOutput("t3_issue_ex_valid", 32'(ex_valid), 32'd1);
      checkOutput("t3_issue_dst", 32'(ex_dst_out), 32'd5);

      // Backpressure from execute
      ex_ready = 1'b0; if_valid = 1'b1; if_instr = 16'h0612; set_ctl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      if_instr = 16'h0777;
      for (int i = 0; i < 3; i++) begin
         checkOutput("t4_hold_ex_valid", 32'(ex_valid), 32'd1);
         checkOutput("t4_hold_dst", 32'(ex_dst_out), 32'd5);
         checkOutput("t4_hold_id_ready", 32'(id_ready), 32'd0);
         cyc();
      end
      ex_ready = 1'b1;
      cyc();
      if_valid = 1'b0;
      checkOutput("t4_release_dst", 32'(ex_dst_out), 32'd6);
      cyc();
      checkOutput("t4_no_loss_dst", 32'(ex_dst_out), 32'd7);

      // Flush with a pending stall and a fetch offered
      if_valid = 1'b1; if_instr = 16'h0800; set_ctl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      if_instr = 16'h0580;
      cyc();
      set_ctl(2'd0, 1'b0, 1'b0, 1'b1, 1'b0); ex_load = 1'b1; ex_dst = 4'd8;
      flush = 1'b1; if_instr = 16'h0999;
      #1;
      checkOutput("t5_stall_before_flush", 32'(stall), 32'd1);
      cyc();
      flush = 1'b0; if_valid = 1'b0; ex_load = 1'b0;
      #1;
      checkOutput("t5_ex_valid", 32'(ex_valid), 32'd0);
      checkOutput("t5_stall", 32'(stall), 32'd0);
      checkOutput("t5_id_ready", 32'(id_ready), 32'd1);
      cyc();
      checkOutput("t5_ifid_empty", 32'(ex_valid), 32'd0);

      // Writeback of r2 in the same cycle it is read
      if_valid = 1'b1; if_instr = 16'h0A20; set_ctl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      if_valid = 1'b0; set_ctl(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      wb_we = 1'b1; wb_dst = 4'd2; wb_data = 16'hBEEF;
      #1;
`ifdef DECODE_WB_BYPASS_EN
      checkOutput("t6_no_stall", 32'(stall), 32'd0);
      cyc();
      wb_we = 1'b0;
`else
      checkOutput("t6_wb_stall", 32'(stall), 32'd1);
      cyc();
      wb_we = 1'b0;
      #1;
      checkOutput("t6_bubble_ex_valid", 32'(ex_valid), 32'd0);
      checkOutput("t6_stall_released", 32'(stall), 32'd0);
      cyc();
`endif
      checkOutput("t6_ex_valid", 32'(ex_valid), 32'd1);
      checkOutput("t6_rdata1", 32'(ex_rdata1), 32'hBEEF);

      // Writes to r0 are dropped and r0 reads as zero
      wb_we = 1'b1; wb_dst = 4'd0; wb_data = 16'hFFFF;
      if_valid = 1'b1; if_instr = 16'h0B00; set_ctl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      if_valid = 1'b0; set_ctl(2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc();
      wb_we = 1'b0;
      checkOutput("t7_r0_rdata1", 32'(ex_rdata1), 32'd0);
      checkOutput("t7_r0_rdata2", 32'(ex_rdata2), 32'd0);

      // Reset while instructions are in flight also clears the register file
      if_valid = 1'b1; if_instr = 16'h0C20; set_ctl(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
      if_instr = 16'h0D30; rst = 1'b1; wb_we = 1'b1; wb_dst = 4'd3; wb_data = 16'h1234;
      cyc();
      rst = 1'b0; if_valid = 1'b0; wb_we = 1'b0;
      #1;
      checkOutput("t8_rst_ex_valid", 32'(ex_valid), 32'd0);
      checkOutput("t8_rst_id_ready", 32'(id_ready), 32'd1);
      if_valid = 1'b1; if_instr = 16'h0C32; set_ctl(2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc();
      if_valid = 1'b0;
      cyc();
      checkOutput("t8_issue_ex_valid", 32'(ex_valid), 32'd1);
      checkOutput("t8_cleared_r3", 32'(ex_rdata1), 32'd0);
      checkOutput("t8_cleared_r2", 32'(ex_rdata2), 32'd0);
      cyc();

      // Randomized traffic against the scoreboard; register model starts from the cleared file
      man_en = 1'b0;
      repeat (600) begin
         @(negedge clk);
         mon_en = 1'b1;
         applyStimulus();
      end
      @(negedge clk);
      idle();
      repeat (6) @(negedge clk);
      #2;
      checkOutput("sb_pending_after_drain", 32'(pending.size()), 32'd0);
      checkOutput("sb_issued_any", 32'(issued > 0), 32'd1);
      mon_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
